// File: rtl/mips_cpu_regfile_lsu_if.sv
// Register-file / load-unit bus: decode read ports, ALU writeback, load issue
// and the data-memory response channel.
interface mips_cpu_regfile_lsu_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned READ_PORTS = 2
);
  localparam int unsigned AW = $clog2(NUM_REGS);
  localparam int unsigned OW = $clog2(DATA_WIDTH / 8);

  logic [READ_PORTS*AW-1:0]         rd_addr;
  logic [READ_PORTS*DATA_WIDTH-1:0] rd_data;
  logic [READ_PORTS-1:0]            rd_busy;
  logic                             wr_en;
  logic [AW-1:0]                    wr_addr;
  logic [DATA_WIDTH-1:0]            wr_data;
  logic                             ld_issue;
  logic                             ld_issue_ready;
  logic [AW-1:0]                    ld_dest;
  logic [2:0]                       ld_mode;
  logic [OW-1:0]                    ld_offset;
  logic                             ld_rvalid;
  logic                             ld_rready;
  logic [DATA_WIDTH-1:0]            ld_rdata;
  logic                             ld_err;
  logic [DATA_WIDTH-1:0]            regv0;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, ld_issue, ld_dest, ld_mode, ld_offset,
    output ld_rvalid, ld_rdata,
    input  rd_data, rd_busy, ld_issue_ready, ld_rready, ld_err, regv0
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, ld_issue, ld_dest, ld_mode, ld_offset,
    input  ld_rvalid, ld_rdata,
    output rd_data, rd_busy, ld_issue_ready, ld_rready, ld_err, regv0
  );
endinterface

// File: rtl/mips_cpu_regfile_lsu.sv
// Multi-port register file with an in-order pending-load queue, per-register
// load scoreboard and MIPS load alignment/merge on retire.
module mips_cpu_regfile_lsu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned LD_DEPTH   = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  mips_cpu_regfile_lsu_if.slave bus
);
  localparam int unsigned AW   = $clog2(NUM_REGS);
  localparam int unsigned NB   = DATA_WIDTH / 8;
  localparam int unsigned OW   = $clog2(NB);
  localparam int unsigned PW   = $clog2(LD_DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int          NB_I = int'(NB);

  typedef enum logic [2:0] {
    ModeLw, ModeLb, ModeLbu, ModeLh, ModeLhu, ModeLwl, ModeLwr, ModeRsvd
  } ld_mode_e;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [CW-1:0]         cnt_q  [NUM_REGS];
  logic [AW-1:0]         q_dest [LD_DEPTH];
  ld_mode_e              q_mode [LD_DEPTH];
  logic [OW-1:0]         q_off  [LD_DEPTH];
  logic [PW:0]           wp_q, rp_q;
  logic                  err_q;

  logic                  full, empty, issue, retire, bad, ld_we;
  logic [AW-1:0]         head_dest;
  ld_mode_e              head_mode;
  logic [OW-1:0]         head_off;
  int                    k;
  logic [7:0]            sel_b;
  logic [15:0]           sel_h;
  logic [DATA_WIDTH-1:0] merged;

  assign full   = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
  assign empty  = (wp_q == rp_q);
  assign issue  = bus.ld_issue && !full;
  assign retire = bus.ld_rvalid && !empty;

  assign bus.ld_issue_ready = !full;
  assign bus.ld_rready      = !empty;
  assign bus.ld_err         = err_q;
  assign bus.regv0          = regs_q[2];

  assign head_dest = q_dest[rp_q[PW-1:0]];
  assign head_mode = q_mode[rp_q[PW-1:0]];
  assign head_off  = q_off[rp_q[PW-1:0]];
  assign k         = int'(head_off);

  // Halfword upper byte taken at offset|1; odd offsets are rejected anyway.
  assign sel_b = bus.ld_rdata[{head_off, 3'b000} +: 8];
  assign sel_h = {bus.ld_rdata[{head_off | OW'(1), 3'b000} +: 8], sel_b};

  always_comb begin
    merged = regs_q[head_dest];
    bad    = 1'b0;
    unique case (head_mode)
      ModeLw:  merged = bus.ld_rdata;
      ModeLb:  merged = {{(DATA_WIDTH-8){sel_b[7]}}, sel_b};
      ModeLbu: merged = {{(DATA_WIDTH-8){1'b0}}, sel_b};
      ModeLh: begin
        merged = {{(DATA_WIDTH-16){sel_h[15]}}, sel_h};
        bad    = head_off[0];
      end
      ModeLhu: begin
        merged = {{(DATA_WIDTH-16){1'b0}}, sel_h};
        bad    = head_off[0];
      end
      ModeLwl: begin
        for (int b = 0; b < NB_I; b++) begin
          if (b >= NB_I - 1 - k) merged[b*8 +: 8] = bus.ld_rdata[(b - (NB_I - 1 - k))*8 +: 8];
        end
      end
      ModeLwr: begin
        for (int b = 0; b < NB_I; b++) begin
          if (b <= NB_I - 1 - k) merged[b*8 +: 8] = bus.ld_rdata[(b + k)*8 +: 8];
        end
      end
      ModeRsvd: bad = 1'b1;
    endcase
  end

  // A same-cycle ALU write to the destination takes precedence over the load.
  assign ld_we = retire && !bad && (head_dest != '0) &&
                 !(bus.wr_en && (bus.wr_addr == head_dest));

  for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_rd
    logic [AW-1:0] a;
    assign a = bus.rd_addr[gi*AW +: AW];
    assign bus.rd_data[gi*DATA_WIDTH +: DATA_WIDTH] =
        (a == '0)                        ? '0 :
        (bus.wr_en && bus.wr_addr == a)  ? bus.wr_data :
        (ld_we && head_dest == a)        ? merged : regs_q[a];
    assign bus.rd_busy[gi] = (cnt_q[a] != '0) &&
                             !((cnt_q[a] == CW'(1)) && retire && (head_dest == a));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      wp_q  <= '0;
      rp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (issue)  wp_q <= wp_q + (PW+1)'(1);
      if (retire) rp_q <= rp_q + (PW+1)'(1);
      err_q <= retire && bad;
      if (bus.wr_en && (bus.wr_addr != '0)) regs_q[bus.wr_addr] <= bus.wr_data;
      if (ld_we) regs_q[head_dest] <= merged;
      for (int r = 1; r < int'(NUM_REGS); r++) begin
        if (issue && bus.ld_dest == AW'(r) && !(retire && head_dest == AW'(r))) begin
          cnt_q[r] <= cnt_q[r] + CW'(1);
        end else if (retire && head_dest == AW'(r) && !(issue && bus.ld_dest == AW'(r))) begin
          cnt_q[r] <= cnt_q[r] - CW'(1);
        end
      end
    end
  end

  // Queue payload needs no reset: only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (issue) begin
      q_dest[wp_q[PW-1:0]] <= bus.ld_dest;
      q_mode[wp_q[PW-1:0]] <= ld_mode_e'(bus.ld_mode);
      q_off[wp_q[PW-1:0]]  <= bus.ld_offset;
    end
  end
endmodule

// File: doc/mips_cpu_regfile_lsu.md
# mips_cpu_regfile_lsu

Parametrised multi-read-port register file for the MIPS CPU, with an integrated in-order pending-load queue and per-register scoreboard. Load results returning from the memory interface are aligned and merged (LB/LBU/LH/LHU/LWL/LWR/LW) from the byte offset captured at issue, not from a read-port value. The block sits between decode/execute (read ports, ALU writeback) and the data-memory response path, and exposes busy flags so the hazard unit can stall.

## Interface
- DATA_WIDTH, 32, register width; multiple of 16 (≥16)
- NUM_REGS, 32, register count; power of two; register 0 hard-wired to zero
- READ_PORTS, 2, number of combinational read ports
- LD_DEPTH, 4, max outstanding loads; power of two
- Derived: AW = log2(NUM_REGS), NB = DATA_WIDTH/8, OW = log2(NB)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  READ_PORTS*AW  packed read selectors, port i at [i*AW +: AW]
- rd_data  out  READ_PORTS*DATA_WIDTH  packed read data (bypassed)
- rd_busy  out  READ_PORTS  selected register still awaits a load
- wr_en  in  1  ALU writeback enable (full-width write)
- wr_addr  in  AW  ALU writeback destination
- wr_data  in  DATA_WIDTH  ALU writeback data
- ld_issue  in  1  enqueue a load
- ld_issue_ready  out  1  queue not full
- ld_dest  in  AW  load destination
- ld_mode  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 reserved
- ld_offset  in  OW  effective-address byte offset
- ld_rvalid  in  1  memory response valid
- ld_rready  out  1  block accepts response
- ld_rdata  in  DATA_WIDTH  aligned memory word
- ld_err  out  1  one-cycle pulse: illegal retire
- regv0  out  DATA_WIDTH  debug view of register 2 (unbypassed)

## Operation
- Storage: NUM_REGS×DATA_WIDTH array; reg 0 reads 0, never written.
- Load queue: FIFO of {dest, mode, offset}, LD_DEPTH entries; wr/rd pointers with one extra wrap bit; full = pointers equal except the MSB.
- Issue: accepted when ld_issue && ld_issue_ready; ld_issue_ready = !full. No issue while full, even if a retire occurs that cycle.
- Retire: ld_rready = !empty; handshake when ld_rvalid && ld_rready. Pops head and computes the merged value from the head entry and the current register contents. Byte lanes b = 0..NB-1; k = offset:
  - LW: whole word. k ignored.
  - LB/LBU: byte k, sign-/zero-extended.
  - LH/LHU: bytes k, k+1, sign-/zero-extended. k odd → error.
  - LWL: dest bytes [NB-1 : NB-1-k] ← mem bytes [k:0]; other bytes kept.
  - LWR: dest bytes [NB-1-k : 0] ← mem bytes [NB-1 : k]; other bytes kept.
  - Mode 7 or odd-k halfword: no register write; ld_err pulses the next cycle; the entry is still popped and the scoreboard decremented.
- Scoreboard: per-register counter, width log2(LD_DEPTH)+1.
  - +1 on issue (dest≠0); −1 on retire.
  - Increment and decrement to the same register in one cycle leaves the counter unchanged.
- Write conflict: ALU write and load write to the same register in one cycle → ALU wins; the load write is dropped, retire completes.
- WAW: an ALU write to a busy register is performed; a later retire may overwrite it.
- Reads: rd_data is bypassed with priority: addr 0 → 0; ALU write this cycle; retiring merged value this cycle; array.
- rd_busy: asserted when count≠0, except when count==1 and that register retires this cycle.

## Timing
- Reset (async assert, sync release) sets:
  - all registers 0, queue empty, counters 0
  - ld_err 0, ld_issue_ready 1, ld_rready 0, rd_busy 0, regv0 0
- rd_data and rd_busy: zero-cycle combinational.
- Array writes and counter updates: at the rising edge after the handshake/enable.
- ld_err: registered, one cycle wide.
- Throughput: one issue and one retire per cycle.
- Reset mid-operation discards all outstanding loads; responses arriving during or after reset are ignored (ld_rready 0).

## Test plan
- Reset/basic: write 0xDEADBEEF to r5, write 1 to r0 → r5 reads 0xDEADBEEF; r0 reads 0; same-cycle read of r5 during the write returns the new data.
- Byte/half loads: issue LB r3 k=2, respond 0x12F45678 → r3=0xFFFFFFF4. LBU same → 0x000000F4. LH k=2 → 0x000012F4. LHU k=1 → no write, ld_err pulse.
- LWL/LWR merge: r4=0xAABBCCDD. LWL k=1 with 0x11223344 → 0x3344CCDD. LWR k=1 with 0x11223344 → 0xAA112233.
- Queue full/backpressure (LD_DEPTH=4): issue 4 loads → ld_issue_ready 0; fifth issue ignored; retire one → ready 1 next cycle; responses retire in issue order.
- Scoreboard: two loads to r7 → rd_busy stays 1 after the first retire, drops in the cycle of the second retire. Issue + retire to r7 in the same cycle → count unchanged.
- Conflict/reset: ALU write r9=5 same cycle as LW retire r9=7 → r9=5. Assert rst_n low with 3 loads pending → all regs 0, ld_rready 0, rd_busy 0.
